axi_byte_slave_mem: RTL and testbench
=====================================

// Module: axi_byte_slave_mem
// PURPOSE
//   Burst responder for the master's byte-wide read/write bus. Holds 2**ADDR_W bytes
//   of storage and serves AR/R read bursts and AW/W/B write bursts concurrently.
//   Read and write paths use independent FSMs. Sits opposite the bus master in the
//   system bench as the target memory.
// PARAMETERS
//   ADDR_W     8   byte address width; storage depth = 2**ADDR_W
//   MAX_BEATS  16  maximum write beats accepted per burst before error
// PORTS
//   clk      in   1   clock, rising edge
//   rst      in   1   reset, asynchronous, active-high
//   ARVALID  in   1   read address valid
//   ARIN     in   16  {ARADDR[15:8], ARLEN[7:4], ARID[3:0]}; beats = ARLEN+1
//   ARREADY  out  1   read address accepted
//   RVALID   out  1   read beat valid
//   RDOUT    out  9   {RDATA[8:1], RRESP[0]}; RRESP 0=OKAY
//   RLAST    out  1   final read beat
//   RREADY   in   1   master accepts read beat
//   AWVALID  in   1   write address valid
//   AWIN     in   12  {AWADDR[11:4], AWID[3:0]}
//   AWREADY  out  1   write address accepted
//   WVALID   in   1   write beat valid
//   WDATA    in   8   write byte
//   WLAST    in   1   final write beat
//   WREADY   out  1   write beat accepted
//   BVALID   out  1   write response valid
//   BRESP    out  5   {BID[4:1], ERR[0]}
//   BREADY   in   1   master accepts write response
// BEHAVIOUR
//   Reset: ARREADY=1, AWREADY=1; RVALID, RLAST, WREADY, BVALID=0; RDOUT=0, BRESP=0;
//     both FSMs to IDLE. Storage array is not reset (contents retained).
//   Read FSM R_IDLE -> R_DATA:
//     R_IDLE: ARREADY=1. On ARVALID&&ARREADY latch addr, len, id; ARREADY<=0.
//       Next cycle RVALID=1, RDOUT={mem[addr],1'b0}, RLAST=(len==0). Latency 1 clk.
//     R_DATA: ARREADY=0. Beat completes on RVALID&&RREADY; hold RDOUT/RLAST stable
//       while RREADY=0. After a non-last beat: addr<=addr+1 (mod 2**ADDR_W, wraps
//       0xFF->0x00), next byte presented next cycle, beat counter+1, RLAST when
//       counter==len. After last beat: RVALID=0, RLAST=0, ARREADY=1, back to R_IDLE.
//   Write FSM W_IDLE -> W_DATA -> W_RESP:
//     W_IDLE: AWREADY=1, WREADY=0. On AWVALID&&AWREADY latch addr, id; AWREADY<=0,
//       WREADY<=1, clear beat count and err flag.
//     W_DATA: each WVALID&&WREADY writes WDATA to mem[addr] at that edge; addr+1
//       with wrap; count+1. Beats beyond MAX_BEATS are not stored and set err.
//       WVALID&&WLAST: WREADY<=0, BVALID<=1, BRESP<={id,err}, go W_RESP.
//     W_RESP: hold BVALID/BRESP until BREADY; then BVALID=0, BRESP=0, AWREADY=1,
//       W_IDLE.
//   ARREADY is 0 outside R_IDLE and AWREADY is 0 outside W_IDLE; the master relies
//     on RVALID&&!ARREADY and WREADY&&!AWREADY to detect the data phase.
//   Simultaneous read and write of the same byte in one cycle: read returns the
//     pre-write value; the write lands at that edge.
//   Read and write bursts proceed independently; neither stalls the other.
//   Reset mid-burst: in-flight burst is abandoned; bytes already written stay in
//     storage; no response is issued for the aborted burst.
//   Counters are 5 bits wide; ARLEN=15 yields 16 beats without overflow.
// TESTING
//   1. Write burst AWIN={0x10,0x3}, bytes 11,22,33,44, WLAST on 4th -> BVALID=1,
//      BRESP=0x06; mem[0x10..0x13]=11,22,33,44.
//   2. Read ARIN={0x10,4'd3,4'd5} -> 4 beats RDOUT data 11,22,33,44, RRESP=0,
//      RLAST only on 4th, ARREADY=0 throughout.
//   3. RREADY held low 3 cycles mid-burst -> RDOUT and RLAST frozen; no beat lost.
//   4. Write 2 bytes at 0xFF, then read 0xFF with len 1 -> data returned from
//      0xFF then 0x00 (wrap).
//   5. 17-beat write with WLAST on beat 17 -> BRESP ERR=1; beat 17 not stored.
//   6. rst pulse during R_DATA -> RVALID=0, ARREADY=1 immediately; next read is
//      served normally.

Source files
------------

// File: rtl/axi_byte_slave_mem.sv
// Byte-wide burst target memory: AR/R read bursts and AW/W/B write bursts served
// by two independent FSMs sharing one storage array (read-before-write on collision).
module axi_byte_slave_mem #(
   parameter int ADDR_W    = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ARVALID,
   input  logic [15:0] ARIN,
   output logic        ARREADY,
   output logic        RVALID,
   output logic [8:0]  RDOUT,
   output logic        RLAST,
   input  logic        RREADY,
   input  logic        AWVALID,
   input  logic [11:0] AWIN,
   output logic        AWREADY,
   input  logic        WVALID,
   input  logic [7:0]  WDATA,
   input  logic        WLAST,
   output logic        WREADY,
   output logic        BVALID,
   output logic [4:0]  BRESP,
   input  logic        BREADY
);
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   localparam logic [4:0] MAX_BEATS_C = MAX_BEATS[4:0];

   logic [7:0]        mem_q [2**ADDR_W];

   r_state_t          r_state_q;
   logic [ADDR_W-1:0] raddr_q, raddr_d, ar_addr;
   logic [3:0]        rlen_q;
   logic [4:0]        rcnt_q, rcnt_d;
   logic              ar_ready_q, r_valid_q, r_last_q;
   logic [8:0]        r_dout_q;

   w_state_t          w_state_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [3:0]        wid_q;
   logic [4:0]        wcnt_q;
   logic              werr_q, werr_d;
   logic              aw_ready_q, w_ready_q, b_valid_q;
   logic [4:0]        b_resp_q;
   logic              w_beat, w_store;

   // The read ID has no return channel; fold it away explicitly.
   logic              unused_arid;
   assign unused_arid = ^ARIN[3:0];

   assign ar_addr = ARIN[8 +: ADDR_W];
   assign raddr_d = raddr_q + ADDR_W'(1);
   assign rcnt_d  = rcnt_q + 5'd1;

   // WREADY is high for the whole of W_DATA, so WVALID alone marks a beat there.
   assign w_beat  = (w_state_q == W_DATA) && WVALID;
   assign w_store = w_beat && (wcnt_q < MAX_BEATS_C);
   assign werr_d  = werr_q | (w_beat & ~w_store);

   always_ff @(posedge clk) begin
      if (w_store) mem_q[waddr_q] <= WDATA;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q  <= R_IDLE;
         raddr_q    <= '0;
         rlen_q     <= '0;
         rcnt_q     <= '0;
         ar_ready_q <= 1'b1;
         r_valid_q  <= 1'b0;
         r_last_q   <= 1'b0;
         r_dout_q   <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (ARVALID) begin
                  raddr_q    <= ar_addr;
                  rlen_q     <= ARIN[7:4];
                  rcnt_q     <= '0;
                  r_dout_q   <= {mem_q[ar_addr], 1'b0};
                  r_last_q   <= (ARIN[7:4] == 4'd0);
                  r_valid_q  <= 1'b1;
                  ar_ready_q <= 1'b0;
                  r_state_q  <= R_DATA;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  if (r_last_q) begin
                     r_valid_q  <= 1'b0;
                     r_last_q   <= 1'b0;
                     ar_ready_q <= 1'b1;
                     r_state_q  <= R_IDLE;
                  end else begin
                     raddr_q  <= raddr_d;
                     rcnt_q   <= rcnt_d;
                     r_dout_q <= {mem_q[raddr_d], 1'b0};
                     r_last_q <= (rcnt_d == {1'b0, rlen_q});
                  end
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q  <= W_IDLE;
         waddr_q    <= '0;
         wid_q      <= '0;
         wcnt_q     <= '0;
         werr_q     <= 1'b0;
         aw_ready_q <= 1'b1;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (AWVALID) begin
                  waddr_q    <= AWIN[4 +: ADDR_W];
                  wid_q      <= AWIN[3:0];
                  wcnt_q     <= '0;
                  werr_q     <= 1'b0;
                  aw_ready_q <= 1'b0;
                  w_ready_q  <= 1'b1;
                  w_state_q  <= W_DATA;
               end
            end
            W_DATA: begin
               if (WVALID) begin
                  // Overflow beats are dropped without advancing the address.
                  if (w_store) begin
                     waddr_q <= waddr_q + ADDR_W'(1);
                     wcnt_q  <= wcnt_q + 5'd1;
                  end
                  werr_q <= werr_d;
                  if (WLAST) begin
                     w_ready_q <= 1'b0;
                     b_valid_q <= 1'b1;
                     b_resp_q  <= {wid_q, werr_d};
                     w_state_q <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  b_valid_q  <= 1'b0;
                  b_resp_q   <= '0;
                  aw_ready_q <= 1'b1;
                  w_state_q  <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   assign ARREADY = ar_ready_q;
   assign RVALID  = r_valid_q;
   assign RDOUT   = r_dout_q;
   assign RLAST   = r_last_q;
   assign AWREADY = aw_ready_q;
   assign WREADY  = w_ready_q;
   assign BVALID  = b_valid_q;
   assign BRESP   = b_resp_q;
endmodule

// File: tb/tb_axi_byte_slave_mem.sv
// Bench for axi_byte_slave_mem: vector table, hand-written corner sequences and
// randomized concurrent bursts checked against a flat byte-array memory model.
module tb_axi_byte_slave_mem;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ARVALID = 1'b0;
   logic [15:0] ARIN = '0;
   logic        ARREADY, RVALID, RLAST;
   logic [8:0]  RDOUT;
   logic        RREADY = 1'b0;
   logic        AWVALID = 1'b0;
   logic [11:0] AWIN = '0;
   logic        AWREADY;
   logic        WVALID = 1'b0;
   logic [7:0]  WDATA = '0;
   logic        WLAST = 1'b0;
   logic        WREADY, BVALID;
   logic [4:0]  BRESP;
   logic        BREADY = 1'b0;

   localparam int MAXB = 16;

   axi_byte_slave_mem #(.ADDR_W(8), .MAX_BEATS(MAXB)) dut (
      .clk(clk), .rst(rst),
      .ARVALID(ARVALID), .ARIN(ARIN), .ARREADY(ARREADY),
      .RVALID(RVALID), .RDOUT(RDOUT), .RLAST(RLAST), .RREADY(RREADY),
      .AWVALID(AWVALID), .AWIN(AWIN), .AWREADY(AWREADY),
      .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(WREADY),
      .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] model [0:255];
   logic [7:0] wbuf  [0:31];

   typedef struct {
      bit          is_write;
      logic [7:0]  addr;
      int          n;
      logic [3:0]  id;
      logic [4:0]  exp_bresp;
      logic [31:0] data4;
      int          stall;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Write burst of n beats from wbuf; beats past MAXB must not reach storage.
   task automatic write_burst(input logic [7:0] addr, input logic [3:0] id, input int n,
                              input logic [4:0] exp_bresp, input int bstall);
      chk("aw_ready_idle", AWREADY, 1);
      AWVALID = 1'b1;
      AWIN    = {addr, id};
      @(posedge clk); #1;
      AWVALID = 1'b0;
      chk("aw_ready_busy", AWREADY, 0);
      for (int i = 0; i < n; i++) begin
         chk("w_ready", WREADY, 1);
         WVALID = 1'b1;
         WDATA  = wbuf[i];
         WLAST  = (i == n - 1);
         @(posedge clk); #1;
         if (i < MAXB) model[addr + 8'(i)] = wbuf[i];
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
      chk("w_ready_done", WREADY, 0);
      for (int k = 0; k <= bstall; k++) begin
         chk("b_valid", BVALID, 1);
         chk("b_resp", BRESP, exp_bresp);
         chk("aw_ready_resp", AWREADY, 0);
         if (k == bstall) BREADY = 1'b1;
         @(posedge clk); #1;
      end
      BREADY = 1'b0;
      chk("b_valid_end", BVALID, 0);
      chk("b_resp_end", BRESP, 0);
      chk("aw_ready_end", AWREADY, 1);
      $display("write addr=%02h id=%0h beats=%0d bresp=%02h", addr, id, n, exp_bresp);
   endtask

   // stall >= 0: hold RREADY low that many cycles before beat 1; stall < 0: random per beat.
   task automatic read_burst(input logic [7:0] addr, input logic [3:0] id, input int n,
                             input int stall);
      logic [7:0] a;
      int         s;
      chk("ar_ready_idle", ARREADY, 1);
      ARVALID = 1'b1;
      ARIN    = {addr, 4'(n - 1), id};
      @(posedge clk); #1;
      ARVALID = 1'b0;
      for (int b = 0; b < n; b++) begin
         a = addr + 8'(b);
         if (stall < 0) s = int'($urandom_range(0, 2));
         else           s = (b == 1) ? stall : 0;
         for (int k = 0; k <= s; k++) begin
            chk("r_valid", RVALID, 1);
            chk("r_data", RDOUT, {model[a], 1'b0});
            chk("r_last", RLAST, (b == n - 1));
            chk("ar_ready_busy", ARREADY, 0);
            if (k == s) RREADY = 1'b1;
            @(posedge clk); #1;
         end
         RREADY = 1'b0;
      end
      chk("r_valid_end", RVALID, 0);
      chk("r_last_end", RLAST, 0);
      chk("ar_ready_end", ARREADY, 1);
      $display("read  addr=%02h id=%0h beats=%0d", addr, id, n);
   endtask

   initial begin
      logic [7:0] old;

      vecs[0]  = '{1'b1, 8'h10, 4,  4'h3, 5'h06, 32'h11223344, 0};
      vecs[1]  = '{1'b0, 8'h10, 4,  4'h5, 5'h00, 32'h0,        0};
      vecs[2]  = '{1'b0, 8'h10, 4,  4'h5, 5'h00, 32'h0,        3};
      vecs[3]  = '{1'b1, 8'hFF, 2,  4'h1, 5'h02, 32'hAABB0000, 0};
      vecs[4]  = '{1'b0, 8'hFF, 2,  4'h0, 5'h00, 32'h0,        0};
      vecs[5]  = '{1'b1, 8'h20, 17, 4'h7, 5'h0F, 32'hDEADBEEF, 2};
      vecs[6]  = '{1'b0, 8'h20, 16, 4'h2, 5'h00, 32'h0,        1};
      vecs[7]  = '{1'b0, 8'h30, 1,  4'h2, 5'h00, 32'h0,        0};
      vecs[8]  = '{1'b1, 8'h40, 1,  4'hF, 5'h1E, 32'h5A000000, 0};
      vecs[9]  = '{1'b0, 8'h40, 1,  4'h9, 5'h00, 32'h0,        0};
      vecs[10] = '{1'b1, 8'hF8, 16, 4'h0, 5'h00, 32'h01020304, 1};
      vecs[11] = '{1'b0, 8'hF8, 16, 4'h4, 5'h00, 32'h0,        -1};
      vecs[12] = '{1'b1, 8'h60, 20, 4'h9, 5'h13, 32'hC0FFEE00, 0};
      vecs[13] = '{1'b0, 8'h60, 16, 4'h1, 5'h00, 32'h0,        2};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ar_ready", ARREADY, 1);
      chk("rst_aw_ready", AWREADY, 1);
      chk("rst_r_valid", RVALID, 0);
      chk("rst_r_last", RLAST, 0);
      chk("rst_w_ready", WREADY, 0);
      chk("rst_b_valid", BVALID, 0);
      chk("rst_rdout", RDOUT, 0);
      chk("rst_bresp", BRESP, 0);

      // Give every byte a known value so any later read has a model reference.
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
         write_burst(8'(k * 16), 4'(k), 16, {4'(k), 1'b0}, 0);
      end

      for (int v = 0; v < 14; v++) begin
         for (int i = 0; i < 32; i++) wbuf[i] = 8'($urandom);
         for (int i = 0; i < 4; i++) wbuf[i] = vecs[v].data4[31 - 8 * i -: 8];
         for (int i = MAXB; i < 32; i++) wbuf[i] = ~model[vecs[v].addr + 8'(i)];
         if (vecs[v].is_write)
            write_burst(vecs[v].addr, vecs[v].id, vecs[v].n, vecs[v].exp_bresp, vecs[v].stall);
         else
            read_burst(vecs[v].addr, vecs[v].id, vecs[v].n, vecs[v].stall);
      end

      // Same-cycle read and write of one byte: read sees the old value.
      old     = model[8'h50];
      AWVALID = 1'b1;
      AWIN    = {8'h50, 4'h2};
      @(posedge clk); #1;
      AWVALID = 1'b0;
      WVALID  = 1'b1;
      WDATA   = ~old;
      WLAST   = 1'b1;
      ARVALID = 1'b1;
      ARIN    = {8'h50, 4'd0, 4'h6};
      @(posedge clk); #1;
      WVALID  = 1'b0;
      WLAST   = 1'b0;
      ARVALID = 1'b0;
      chk("rw_r_valid", RVALID, 1);
      chk("rw_r_data_old", RDOUT, {old, 1'b0});
      chk("rw_r_last", RLAST, 1);
      chk("rw_b_valid", BVALID, 1);
      chk("rw_b_resp", BRESP, 5'h04);
      RREADY = 1'b1;
      BREADY = 1'b1;
      @(posedge clk); #1;
      RREADY = 1'b0;
      BREADY = 1'b0;
      chk("rw_r_valid_end", RVALID, 0);
      chk("rw_b_valid_end", BVALID, 0);
      model[8'h50] = ~old;
      $display("rw    addr=50 same-cycle read/write");
      read_burst(8'h50, 4'h6, 1, 0);

      // Reset in the middle of a read and a write burst.
      ARVALID = 1'b1;
      ARIN    = {8'h10, 4'd3, 4'h0};
      AWVALID = 1'b1;
      AWIN    = {8'h70, 4'h4};
      @(posedge clk); #1;
      ARVALID = 1'b0;
      AWVALID = 1'b0;
      chk("mid_r_valid", RVALID, 1);
      WVALID = 1'b1;
      WDATA  = ~model[8'h70];
      @(posedge clk); #1;
      model[8'h70] = WDATA;
      WDATA = ~model[8'h71];
      @(posedge clk); #1;
      model[8'h71] = WDATA;
      WVALID = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst_r_valid", RVALID, 0);
      chk("arst_ar_ready", ARREADY, 1);
      chk("arst_r_last", RLAST, 0);
      chk("arst_aw_ready", AWREADY, 1);
      chk("arst_w_ready", WREADY, 0);
      chk("arst_b_valid", BVALID, 0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("arst_b_valid_after", BVALID, 0);
      $display("reset mid-burst");
      read_burst(8'h70, 4'h3, 2, 0);
      read_burst(8'h10, 4'h5, 4, 1);

      // Concurrent random bursts on disjoint regions.
      for (int t = 0; t < 30; t++) begin
         logic [7:0] wa, ra;
         logic [3:0] wid, rid;
         int         wn, rn, bs;
         wa  = 8'h80 + 8'($urandom_range(0, 63));
         ra  = 8'($urandom_range(0, 63));
         wid = 4'($urandom);
         rid = 4'($urandom);
         wn  = int'($urandom_range(1, 20));
         rn  = int'($urandom_range(1, 16));
         bs  = int'($urandom_range(0, 2));
         for (int i = 0; i < 32; i++) wbuf[i] = 8'($urandom);
         fork
            write_burst(wa, wid, wn, {wid, (wn > MAXB)}, bs);
            read_burst(ra, rid, rn, -1);
         join
      end

      // Random sequential reads anywhere, including the region just written.
      for (int t = 0; t < 20; t++) begin
         read_burst(8'($urandom), 4'($urandom), int'($urandom_range(1, 16)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
